// File: rtl/imem_refill_pkg.sv
// rtl/imem_refill_pkg.sv - shared refill constants, FSM state encoding and width helper.
package imem_refill_pkg;

  localparam int IMEM_LINE        = 256;
  localparam int IMEM_REFILL_BEAT = 64;
  localparam int IMEM_BLK_LEN     = 64 - $clog2(IMEM_LINE / 8);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_RESP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A one-beat line still needs a 1-bit counter to keep the port widths legal.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/imem_refill_lbuf.sv
// rtl/imem_refill_lbuf.sv - one-entry refill line buffer, built only with IMEM_REFILL_LBUF_EN.
`ifdef IMEM_REFILL_LBUF_EN
module imem_refill_lbuf #(
  parameter int TAG_W  = 59,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inv_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] line_o
);

  logic              v_q, v_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] line_q, line_d;

  // Invalidate wins over a same-cycle fill.
  always_comb begin
    v_d    = v_q;
    tag_d  = tag_q;
    line_d = line_q;
    if (inv_i) begin
      v_d = 1'b0;
    end else if (fill_i) begin
      v_d    = 1'b1;
      tag_d  = fill_tag_i;
      line_d = fill_line_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      tag_q  <= '0;
      line_q <= '0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      line_q <= line_d;
    end
  end

  assign hit_o  = v_q && (tag_q == lookup_tag_i);
  assign line_o = line_q;

endmodule
`endif

// File: rtl/imem_refill.sv
// rtl/imem_refill.sv - I-cache line refill responder, fetching a line as sequential memory beats.
// Optional one-entry line buffer enabled by defining IMEM_REFILL_LBUF_EN.
module imem_refill
  import imem_refill_pkg::*;
#(
  parameter int LINE_W  = IMEM_LINE,
  parameter int BEAT_W  = IMEM_REFILL_BEAT,
  parameter int BLK_LEN = 64 - $clog2(LINE_W / 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b_rd_i,
  input  logic [BLK_LEN-1:0] b_addr_i,
  output logic [LINE_W-1:0]  b_data_i,
  output logic               b_dv_i,
  input  logic               inv,
  output logic [63:0]        m_addr,
  output logic               m_rd,
  input  logic [BEAT_W-1:0]  m_data,
  input  logic               m_ack
);

  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int CNT_W    = cnt_width(BEATS);
  localparam int LINE_OFF = $clog2(LINE_W / 8);
  localparam int BEAT_OFF = $clog2(BEAT_W / 8);

  state_e             state_q, state_d;
  logic [BLK_LEN-1:0] blk_q, blk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               last_beat;
  logic               buf_hit;
  logic [LINE_W-1:0]  buf_line;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign b_data_i  = line_q;
  assign m_addr    = 64'({blk_q, {LINE_OFF{1'b0}}}) | (64'(cnt_q) << BEAT_OFF);

`ifdef IMEM_REFILL_LBUF_EN
  logic inv_pend_q;
  logic buf_fill;
  logic buf_hit_raw;

  // Remembers an invalidate seen since the request left IDLE, so that line is not buffered.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE) begin
      inv_pend_q <= 1'b0;
    end else if (inv) begin
      inv_pend_q <= 1'b1;
    end
  end

  assign buf_fill = (state_q == ST_BURST) && m_ack && last_beat && !inv && !inv_pend_q;
  assign buf_hit  = buf_hit_raw && !inv;

  imem_refill_lbuf #(
    .TAG_W  (BLK_LEN),
    .LINE_W (LINE_W)
  ) u_lbuf (
    .clk          (clk),
    .rst          (rst),
    .inv_i        (inv),
    .fill_i       (buf_fill),
    .fill_tag_i   (blk_q),
    .fill_line_i  (line_d),
    .lookup_tag_i (b_addr_i),
    .hit_o        (buf_hit_raw),
    .line_o       (buf_line)
  );
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign buf_hit    = 1'b0;
  assign buf_line   = '0;
`endif

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    m_rd    = 1'b0;
    b_dv_i  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (b_rd_i) state_d = ST_ADDR;
      end
      // The requestor presents its address one cycle late, so sample at the end of ADDR.
      ST_ADDR: begin
        if (!b_rd_i) begin
          state_d = ST_IDLE;
        end else if (buf_hit) begin
          blk_d   = b_addr_i;
          line_d  = buf_line;
          state_d = ST_RESP;
        end else begin
          blk_d   = b_addr_i;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        m_rd = 1'b1;
        if (m_ack) begin
          line_d[BEAT_W*int'(cnt_q) +: BEAT_W] = m_data;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        b_dv_i  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_imem_refill.sv
// tb/tb_imem_refill.sv - scoreboard bench for imem_refill; line-buffer cases need IMEM_REFILL_LBUF_EN.
module tb_imem_refill;

  logic          clk;
  logic          rst;
  logic          b_rd_i;
  logic [58:0]   b_addr_i;
  logic [255:0]  b_data_i;
  logic          b_dv_i;
  logic          inv;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic [63:0]   m_data;
  logic          m_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;

  logic [63:0]  exp_addr[$];
  logic [255:0] exp_line[$];

  imem_refill dut (
    .clk      (clk),
    .rst      (rst),
    .b_rd_i   (b_rd_i),
    .b_addr_i (b_addr_i),
    .b_data_i (b_data_i),
    .b_dv_i   (b_dv_i),
    .inv      (inv),
    .m_addr   (m_addr),
    .m_rd     (m_rd),
    .m_data   (m_data),
    .m_ack    (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction

  function automatic logic [255:0] line_of(input logic [58:0] blk);
    logic [63:0] base;
    base = {blk, 5'b0};
    return {mem_word(base + 64'd24), mem_word(base + 64'd16),
            mem_word(base + 64'd8), mem_word(base)};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles and checks the request is held while stalled.
  initial begin : responder
    logic        held;
    logic [63:0] held_addr;
    int          wait_cnt;
    held = 1'b0;
    held_addr = '0;
    wait_cnt = 0;
    m_ack = 1'b0;
    m_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (held && m_rd) chk("stall_addr_stable", 256'(m_addr), 256'(held_addr));
      if (!m_rd) begin
        m_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        m_ack = 1'b1;
        m_data = mem_word(m_addr);
        wait_cnt = 0;
      end else begin
        m_ack = 1'b0;
        wait_cnt++;
      end
      held = m_rd && !m_ack;
      held_addr = m_addr;
    end
  end

  always @(negedge clk) begin
    if (m_rd && m_ack) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %0h expected no beat", m_addr);
      end else begin
        chk("beat_addr", 256'(m_addr), 256'(exp_addr.pop_front()));
      end
    end
    if (b_dv_i) begin
      if (exp_line.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dv: got line %0h expected no dv", b_data_i);
      end else begin
        chk("line_data", b_data_i, exp_line.pop_front());
      end
    end
  end

  task automatic do_req(input logic [58:0] blk, input int exp_lat, input bit hit);
    int  t0;
    bit  got;
    if (!hit) begin
      for (int i = 0; i < 4; i++) exp_addr.push_back({blk, 5'b0} + 64'(i * 8));
    end
    exp_line.push_back(line_of(blk));
    @(posedge clk);
    #2;
    b_rd_i = 1'b1;
    b_addr_i = 59'h1ABC;
    t0 = cyc;
    @(posedge clk);
    #2;
    b_addr_i = blk;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (b_dv_i) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL dv_timeout: got no dv expected dv for block %0h", blk);
    end else begin
      chk("dv_latency", 256'(cyc - t0), 256'(exp_lat));
    end
    @(posedge clk);
    #2;
    b_rd_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0;
    rst = 1'b1;
    b_rd_i = 1'b0;
    b_addr_i = '0;
    inv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_m_rd", 256'(m_rd), 256'(0));
    chk("reset_dv", 256'(b_dv_i), 256'(0));
    chk("reset_m_addr", 256'(m_addr), 256'(0));
    chk("reset_b_data", b_data_i, 256'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;

    ack_delay = 0;
    do_req(59'h12, 6, 1'b0);
    ack_delay = 3;
    do_req(59'h13, 18, 1'b0);
    ack_delay = 0;
    do_req(59'h5, 6, 1'b0);
    do_req(59'h7, 6, 1'b0);
    do_req(59'h8, 6, 1'b0);

    for (int i = 0; i < 3; i++) exp_addr.push_back({59'h20, 5'b0} + 64'(i * 8));
    @(posedge clk);
    #2;
    b_rd_i = 1'b1;
    b_addr_i = 59'h1ABC;
    t0 = cyc;
    @(posedge clk);
    #2;
    b_addr_i = 59'h20;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_test_cycle", 256'(cyc - t0), 256'(4));
    rst = 1'b1;
    b_rd_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_m_rd", 256'(m_rd), 256'(0));
    chk("rst_abort_dv", 256'(b_dv_i), 256'(0));
    repeat (4) @(negedge clk);
    chk("rst_abort_idle", 256'(m_rd), 256'(0));
    do_req(59'h12, 6, 1'b0);

`ifdef IMEM_REFILL_LBUF_EN
    do_req(59'h12, 2, 1'b1);
    @(posedge clk);
    #2;
    inv = 1'b1;
    @(posedge clk);
    #2;
    inv = 1'b0;
    do_req(59'h12, 6, 1'b0);
`endif

    repeat (4) @(posedge clk);
    chk("beats_drained", 256'(exp_addr.size()), 256'(0));
    chk("lines_drained", 256'(exp_line.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
